// File: rtl/sound_pkg.sv
// Shared constants and address decode for the noise-channel register block.
package sound_pkg;

  localparam logic [15:0] NR41_ADDR = 16'hFF20;
  localparam logic [15:0] NR42_ADDR = 16'hFF21;
  localparam logic [15:0] NR43_ADDR = 16'hFF22;
  localparam logic [15:0] NR44_ADDR = 16'hFF23;

  // Bits that always read back as 1 (write-only or unused positions).
  localparam logic [7:0] NR41_READ_MASK = 8'hFF;
  localparam logic [7:0] NR44_READ_MASK = 8'hBF;

  localparam int PRESCALE_DEFAULT     = 8192;
  localparam int START_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEL_NR41,
    SEL_NR42,
    SEL_NR43,
    SEL_NR44
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } reg_dec_t;

  function automatic reg_dec_t decode_addr(input logic [15:0] addr);
    reg_dec_t r;
    r.hit = 1'b1;
    r.sel = SEL_NR41;
    case (addr)
      NR41_ADDR: r.sel = SEL_NR41;
      NR42_ADDR: r.sel = SEL_NR42;
      NR43_ADDR: r.sel = SEL_NR43;
      NR44_ADDR: r.sel = SEL_NR44;
      default:   r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sound_frame_seq.sv
// Frame sequencer: prescaled 8-step counter producing the length and
// envelope clocks. Held at step 0 while disabled.
module sound_frame_seq
  import sound_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic clk_length_ctr,
  output logic clk_vol_env
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    step_q, step_d;
  logic          len_q, len_d;
  logic          env_q, env_d;

  always_comb begin
    presc_d = presc_q;
    step_d  = step_q;
    if (!enable) begin
      presc_d = '0;
      step_d  = '0;
    end else if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      step_d  = step_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // Decoded from the next step so the flops always mirror the current step.
    len_d = ~step_d[0];
    env_d = (step_d == 3'd7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      step_q  <= '0;
      len_q   <= 1'b1;
      env_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      len_q   <= len_d;
      env_q   <= env_d;
    end
  end

  assign clk_length_ctr = len_q;
  assign clk_vol_env    = env_q;

endmodule

// File: rtl/sound_noise_regs.sv
// Noise channel registers NR41-NR44: CPU write/readback, trigger pulse
// generation and the frame-sequencer clocks.
module sound_noise_regs
  import sound_pkg::*;
#(
  parameter int PRESCALE     = PRESCALE_DEFAULT,
  parameter int START_CYCLES = START_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        wr,
  input  logic        rd,
  input  logic        apu_enable,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [3:0]  shift_clock_freq,
  output logic        counter_width,
  output logic [2:0]  freq_dividing_ratio,
  output logic        single,
  output logic        start,
  output logic        clk_length_ctr,
  output logic        clk_vol_env
);

  localparam int CW = $clog2(START_CYCLES + 1);

  logic [5:0]    len_q, len_d;
  logic [7:0]    nr42_q, nr42_d;
  logic [7:0]    nr43_q, nr43_d;
  logic          single_q, single_d;
  logic [CW-1:0] pulse_q, pulse_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    rdata;
  reg_dec_t      dec;

  assign dec = decode_addr(a);

  always_comb begin
    len_d    = len_q;
    nr42_d   = nr42_q;
    nr43_d   = nr43_q;
    single_d = single_q;
    pulse_d  = pulse_q;
    if (pulse_q != '0) pulse_d = pulse_q - CW'(1);
    if (!apu_enable) begin
      len_d    = '0;
      nr42_d   = '0;
      nr43_d   = '0;
      single_d = 1'b0;
      pulse_d  = '0;
    end else if (wr && dec.hit) begin
      case (dec.sel)
        SEL_NR41: len_d  = din[5:0];
        SEL_NR42: nr42_d = din;
        SEL_NR43: nr43_d = din;
        SEL_NR44: begin
          single_d = din[6];
          // A retrigger simply reloads the counter.
          if (din[7]) pulse_d = CW'(START_CYCLES);
        end
        default: ;
      endcase
    end
  end

  // Readback uses the registered (pre-write) values.
  always_comb begin
    rdata = 8'hFF;
    if (dec.hit) begin
      case (dec.sel)
        SEL_NR41: rdata = NR41_READ_MASK;
        SEL_NR42: rdata = nr42_q;
        SEL_NR43: rdata = nr43_q;
        SEL_NR44: rdata = NR44_READ_MASK | {1'b0, single_q, 6'b0};
        default:  rdata = 8'hFF;
      endcase
    end
    dout_d = rd ? rdata : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      nr42_q   <= '0;
      nr43_q   <= '0;
      single_q <= 1'b0;
      pulse_q  <= '0;
      dout_q   <= '0;
    end else begin
      len_q    <= len_d;
      nr42_q   <= nr42_d;
      nr43_q   <= nr43_d;
      single_q <= single_d;
      pulse_q  <= pulse_d;
      dout_q   <= dout_d;
    end
  end

  assign dout                = dout_q;
  assign length              = len_q;
  assign initial_volume      = nr42_q[7:4];
  assign envelope_increasing = nr42_q[3];
  assign num_envelope_sweeps = nr42_q[2:0];
  assign shift_clock_freq    = nr43_q[7:4];
  assign counter_width       = nr43_q[3];
  assign freq_dividing_ratio = nr43_q[2:0];
  assign single              = single_q;
  assign start               = (pulse_q != '0);

  sound_frame_seq #(
    .PRESCALE(PRESCALE)
  ) u_frame_seq (
    .clk           (clk),
    .rst           (rst),
    .enable        (apu_enable),
    .clk_length_ctr(clk_length_ctr),
    .clk_vol_env   (clk_vol_env)
  );

endmodule

// File: tb/tb_sound_noise_regs.sv
// Bench for sound_noise_regs: directed register/trigger/sequencer cases plus
// randomized CPU traffic checked every cycle against a behavioural model.
module tb_sound_noise_regs;

  localparam int P   = 4;
  localparam int SC  = 4;
  localparam int BIG = 1000;

  logic        clk, rst, wr, rd, apu_enable;
  logic [15:0] a;
  logic [7:0]  din, dout;
  logic [5:0]  length;
  logic [3:0]  initial_volume, shift_clock_freq;
  logic        envelope_increasing, counter_width, single, start;
  logic [2:0]  num_envelope_sweeps, freq_dividing_ratio;
  logic        clk_length_ctr, clk_vol_env;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  logic [5:0] m_len;
  logic [7:0] m_nr42, m_nr43, m_dout;
  logic       m_single;
  int         m_en_cycles;  // consecutive enabled edges since reset/disable
  int         m_since;      // edges since last trigger (BIG = none)

  sound_noise_regs #(
    .PRESCALE(P),
    .START_CYCLES(SC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .a                  (a),
    .din                (din),
    .dout               (dout),
    .wr                 (wr),
    .rd                 (rd),
    .apu_enable         (apu_enable),
    .length             (length),
    .initial_volume     (initial_volume),
    .envelope_increasing(envelope_increasing),
    .num_envelope_sweeps(num_envelope_sweeps),
    .shift_clock_freq   (shift_clock_freq),
    .counter_width      (counter_width),
    .freq_dividing_ratio(freq_dividing_ratio),
    .single             (single),
    .start              (start),
    .clk_length_ctr     (clk_length_ctr),
    .clk_vol_env        (clk_vol_env)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [15:0] addr);
    case (addr)
      16'hFF20: return 8'hFF;
      16'hFF21: return m_nr42;
      16'hFF22: return m_nr43;
      16'hFF23: return m_single ? 8'hFF : 8'hBF;
      default:  return 8'hFF;
    endcase
  endfunction

  // ---------------- model ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_len <= '0; m_nr42 <= '0; m_nr43 <= '0; m_single <= 1'b0;
      m_dout <= '0; m_en_cycles <= 0; m_since <= BIG;
    end else begin
      if (rd) m_dout <= m_read(a);
      if (!apu_enable) begin
        m_len <= '0; m_nr42 <= '0; m_nr43 <= '0; m_single <= 1'b0;
        m_en_cycles <= 0; m_since <= BIG;
      end else begin
        m_en_cycles <= m_en_cycles + 1;
        if (m_since < BIG) m_since <= m_since + 1;
        if (wr) begin
          case (a)
            16'hFF20: m_len  <= din[5:0];
            16'hFF21: m_nr42 <= din;
            16'hFF22: m_nr43 <= din;
            16'hFF23: begin
              m_single <= din[6];
              if (din[7]) m_since <= 0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int st;
    if (check_en) begin
      st = (m_en_cycles / P) % 8;
      chk("dout", dout, m_dout);
      chk("length", length, m_len);
      chk("initial_volume", initial_volume, m_nr42[7:4]);
      chk("envelope_increasing", envelope_increasing, m_nr42[3]);
      chk("num_envelope_sweeps", num_envelope_sweeps, m_nr42[2:0]);
      chk("shift_clock_freq", shift_clock_freq, m_nr43[7:4]);
      chk("counter_width", counter_width, m_nr43[3]);
      chk("freq_dividing_ratio", freq_dividing_ratio, m_nr43[2:0]);
      chk("single", single, m_single);
      chk("start", start, m_since < SC);
      chk("clk_length_ctr", clk_length_ctr, (st % 2) == 0);
      chk("clk_vol_env", clk_vol_env, st == 7);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] d);
    a = addr; din = d; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] addr);
    a = addr; rd = 1'b1; wr = 1'b0;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi, vol_hi, rises, first, last;
    logic prev;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; apu_enable = 1'b1; a = '0; din = '0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_start", start, 1'b0);
    chk("rst_len_clk", clk_length_ctr, 1'b1);
    chk("rst_env_clk", clk_vol_env, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);

    // NR42 write and readback
    wr_reg(16'hFF21, 8'hF3);
    rd_reg(16'hFF21);
    chk("nr42_read", dout, 8'hF3);
    chk("nr42_vol", initial_volume, 4'hF);
    chk("nr42_inc", envelope_increasing, 1'b0);
    chk("nr42_sweeps", num_envelope_sweeps, 3'd3);

    // Trigger with single=1
    wr_reg(16'hFF23, 8'hC0);
    chk("trig_single", single, 1'b1);
    hi = int'(start);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start) hi++; else break;
    end
    chk("start_width", 16'(hi), 16'd4);
    rd_reg(16'hFF23);
    chk("nr44_read", dout, 8'hFF);
    rd_reg(16'hFF20);
    chk("nr41_read", dout, 8'hFF);
    rd_reg(16'hFF30);
    chk("other_read", dout, 8'hFF);

    // Retrigger two cycles after the first trigger
    wr_reg(16'hFF23, 8'h80);
    hi = int'(start);
    @(negedge clk);
    hi += int'(start);
    wr_reg(16'hFF23, 8'h80);
    hi += int'(start);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start) hi++; else break;
    end
    chk("retrig_width", 16'(hi), 16'd6);
    rd_reg(16'hFF23);
    chk("nr44_read_s0", dout, 8'hBF);

    // Simultaneous read and write return the old value
    wr_reg(16'hFF22, 8'h12);
    a = 16'hFF22; din = 8'h34; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("rw_old", dout, 8'h12);
    chk("nr43_shift", shift_clock_freq, 4'h3);
    chk("nr43_width", counter_width, 1'b0);
    chk("nr43_ratio", freq_dividing_ratio, 3'd4);
    rd_reg(16'hFF22);
    chk("rw_new", dout, 8'h34);

    // Frame sequencer over 64 cycles
    vol_hi = 0; rises = 0; first = -1; last = -1; prev = clk_length_ctr;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (clk_vol_env) vol_hi++;
      if (clk_length_ctr && !prev) begin
        rises++;
        if (first < 0) first = i;
        last = i;
      end
      prev = clk_length_ctr;
    end
    chk("env_high_cycles", 16'(vol_hi), 16'd8);
    chk("len_rises", 16'(rises), 16'd8);
    chk("len_rise_span", 16'(last - first), 16'd56);

    // Disabled APU: clears and ignores writes
    apu_enable = 1'b0;
    idle();
    wr_reg(16'hFF22, 8'h55);
    rd_reg(16'hFF22);
    chk("dis_read", dout, 8'h00);
    chk("dis_shift", shift_clock_freq, 4'h0);
    wr_reg(16'hFF23, 8'h80);
    chk("dis_start", start, 1'b0);
    chk("dis_len_clk", clk_length_ctr, 1'b1);
    apu_enable = 1'b1;
    idle();
    // Write discarded when enable falls in the same cycle
    a = 16'hFF21; din = 8'hAA; wr = 1'b1; apu_enable = 1'b0;
    @(negedge clk);
    wr = 1'b0; apu_enable = 1'b1;
    rd_reg(16'hFF21);
    chk("fall_discard", dout, 8'h00);

    // Reset in the middle of a pulse
    wr_reg(16'hFF23, 8'hC0);
    rd_reg(16'hFF20);
    chk("pre_rst_start", start, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_start", start, 1'b0);
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_single", single, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 4);
      a   = (sel < 4) ? 16'(16'hFF20 + sel) : 16'($urandom);
      din = 8'($urandom);
      wr  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 30);
      apu_enable = ($urandom_range(0, 99) < ((i < 1500) ? 99 : 90));
      if ($urandom_range(0, 299) == 0) pulse_rst();
      @(negedge clk);
    end
    wr = 1'b0; rd = 1'b0; apu_enable = 1'b1;
    idle();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sound_noise_regs.md
SOUND_NOISE_REGS -- requirements
Module: sound_noise_regs

Interface
REQ-001 SHALL have parameter PRESCALE, default 8192, meaning clk cycles per frame-sequencer step (4.194304 MHz / 8192 = 512 Hz).
REQ-002 SHALL have parameter START_CYCLES, default 4, meaning width in clk cycles of the start pulse.
REQ-003 SHALL use one clock and an asynchronous active-high reset; all ports follow.
REQ-004 clk  input  1  CPU clock, sole clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 a  input  16  CPU address.
REQ-007 din  input  8  CPU write data.
REQ-008 dout  output  8  CPU read data, registered.
REQ-009 wr  input  1  write strobe, one clk cycle per access.
REQ-010 rd  input  1  read strobe.
REQ-011 apu_enable  input  1  master sound enable (NR52 bit 7).
REQ-012 length  output  6  NR41[5:0].
REQ-013 initial_volume  output  4  NR42[7:4].
REQ-014 envelope_increasing  output  1  NR42[3].
REQ-015 num_envelope_sweeps  output  3  NR42[2:0].
REQ-016 shift_clock_freq  output  4  NR43[7:4].
REQ-017 counter_width  output  1  NR43[3].
REQ-018 freq_dividing_ratio  output  3  NR43[2:0].
REQ-019 single  output  1  NR44[6].
REQ-020 start  output  1  trigger pulse to the noise channel.
REQ-021 clk_length_ctr  output  1  256 Hz length clock, registered.
REQ-022 clk_vol_env  output  1  64 Hz envelope clock, registered.

Function
REQ-023 Register map SHALL be: NR41=0xFF20, NR42=0xFF21, NR43=0xFF22, NR44=0xFF23; writes take effect on the clk edge where wr=1 and apu_enable=1.
REQ-024 Readback on the edge after rd=1 SHALL be: NR41 0xFF; NR42 stored byte; NR43 stored byte; NR44 0xBF | (single<<6); any other address 0xFF. dout SHALL hold its value while rd=0.
REQ-025 Write to NR44 with din[7]=1 SHALL drive start=1 from the next cycle for exactly START_CYCLES cycles; start SHALL be high for at most one cycle of overlap with the triggering write.
REQ-026 A retrigger while start=1 SHALL reload the pulse counter, extending start to START_CYCLES cycles after the new write.
REQ-027 The NR44 write that triggers SHALL update single in the same edge, so single is stable before start rises.
REQ-028 Frame sequencer: prescaler counts 0..PRESCALE-1; on wrap, the 3-bit step counter increments mod 8.
REQ-029 clk_length_ctr SHALL equal ~step[0] (rising at steps 0,2,4,6); clk_vol_env SHALL be 1 only while step==7.
REQ-030 apu_enable=0 SHALL, synchronously: clear all NR41-NR44 fields to 0, force start=0, hold prescaler and step at 0, and ignore writes; reads remain functional.
REQ-031 Write and apu_enable falling in the same cycle: write SHALL be discarded.
REQ-032 Simultaneous rd and wr to the same register: dout SHALL return the pre-write value.

Reset
REQ-033 rst=1 SHALL immediately clear all field outputs, start, prescaler, step and dout to 0, giving clk_length_ctr=1 and clk_vol_env=0; a pulse in progress SHALL be terminated.

Structure
REQ-034 Register addresses, the NR41/NR44 readback masks and PRESCALE/START_CYCLES defaults SHALL live in shared package sound_pkg.
REQ-035 The frame sequencer SHALL be sub-module sound_frame_seq (ports clk, rst, enable, clk_length_ctr, clk_vol_env).

Verification
REQ-036 Write 0xF3 to 0xFF21, read -> dout=0xF3; initial_volume=0xF, envelope_increasing=0, num_envelope_sweeps=3.
REQ-037 Write 0xC0 to 0xFF23 -> single=1 same edge, start=1 for 4 cycles; read 0xFF23 -> 0xFF; read 0xFF20 -> 0xFF.
REQ-038 Trigger, then retrigger 2 cycles later -> start high for 6 consecutive cycles total.
REQ-039 PRESCALE=4 -> clk_length_ctr rising every 8 cycles, clk_vol_env high 4 cycles every 32.
REQ-040 apu_enable=0 then write 0x55 to 0xFF22 -> fields read 0x00, no start; rst mid-pulse -> start=0 without clk edge.
